cascade_stage_eval: RTL and testbench

Cascade stage evaluator for the Haar face detector: the responder side of the control FSM's stage handshake. On each `stage_start` it fetches the current stage's feature count and threshold, requests and accumulates one weak-classifier vote per feature from the feature-sum unit, and compares the sum against the stage threshold. It then reports the result with `stage_done` and `stage_passed`. It tracks the stage index and the global feature base, and drives `last_stage` back to the control FSM.

---
 rtl/cascade_stage_eval_if.sv | 14 +
 rtl/cascade_stage_eval.sv | 142 ++++++++++++++
 tb/tb_cascade_stage_eval.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cascade_stage_eval_if.sv
// Feature-sum request/vote handshake between the stage evaluator (master)
// and the feature-sum unit (slave).
interface cascade_stage_eval_if #(
    parameter int FIDX_W = 12,
    parameter int VOTE_W = 16
);
    logic                     feat_req;
    logic [FIDX_W-1:0]        feat_idx;
    logic                     feat_ack;
    logic signed [VOTE_W-1:0] feat_vote;

    modport master (output feat_req, feat_idx, input feat_ack, feat_vote);
    modport slave  (input feat_req, feat_idx, output feat_ack, feat_vote);
endinterface

// File: rtl/cascade_stage_eval.sv
// Haar cascade stage evaluator: accumulates weak-classifier votes for one stage
// and compares against the stage threshold. CASCADE_ACC_SAT_EN selects a saturating accumulator.
module cascade_stage_eval #(
    parameter int NUM_STAGES = 25,
    parameter int SIDX_W     = 5,
    parameter int FIDX_W     = 12,
    parameter int VOTE_W     = 16,
    parameter int ACC_W      = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stage_start,
    input  logic                    window_reset,
    output logic                    stage_done,
    output logic                    stage_passed,
    output logic                    last_stage,
    output logic [SIDX_W-1:0]       stage_idx,
    input  logic [FIDX_W-1:0]       stg_num_feats,
    input  logic signed [ACC_W-1:0] stg_thresh,
    cascade_stage_eval_if.master    feat
);

    typedef enum logic [1:0] {IDLE, LOAD, REQ, CMP} state_t;

    state_t                  state_reg, state_next;
    logic [SIDX_W-1:0]       stage_idx_reg;
    logic [FIDX_W-1:0]       feat_base_reg;
    logic [FIDX_W-1:0]       feat_cnt_reg;
    logic [FIDX_W-1:0]       num_feats_reg;
    logic signed [ACC_W-1:0] thresh_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic                    stage_done_reg;
    logic                    stage_passed_reg;
    logic                    xfer;
    logic                    last_xfer;
    logic                    is_last;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   vote_ext;
    logic signed [ACC_W:0]   sum_ext;

    assign is_last      = (stage_idx_reg == SIDX_W'(NUM_STAGES - 1));
    assign last_stage   = is_last;
    assign stage_idx    = stage_idx_reg;
    assign stage_done   = stage_done_reg;
    assign stage_passed = stage_passed_reg;

    assign feat.feat_req = (state_reg == REQ);
    assign feat.feat_idx = feat_base_reg + feat_cnt_reg;

    assign xfer      = (state_reg == REQ) && feat.feat_ack;
    assign last_xfer = xfer && (feat_cnt_reg == num_feats_reg - 1'b1);

    // One guard bit above the accumulator exposes signed overflow.
    assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    assign vote_ext = {{(ACC_W + 1 - VOTE_W){feat.feat_vote[VOTE_W-1]}}, feat.feat_vote};
    assign sum_ext  = acc_ext + vote_ext;

    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
`ifdef CASCADE_ACC_SAT_EN
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        acc_next = sum_ext[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (window_reset) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (stage_start) state_next = LOAD;
                // Decide on the ROM word directly; it is latched on this same edge.
                LOAD: state_next = (stg_num_feats == '0) ? CMP : REQ;
                REQ:  if (last_xfer) state_next = CMP;
                CMP:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_idx_reg    <= '0;
            feat_base_reg    <= '0;
            feat_cnt_reg     <= '0;
            num_feats_reg    <= '0;
            thresh_reg       <= '0;
            acc_reg          <= '0;
            stage_done_reg   <= 1'b0;
            stage_passed_reg <= 1'b0;
        end else if (window_reset) begin
            stage_idx_reg  <= '0;
            feat_base_reg  <= '0;
            feat_cnt_reg   <= '0;
            acc_reg        <= '0;
            stage_done_reg <= 1'b0;
        end else begin
            stage_done_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    num_feats_reg <= stg_num_feats;
                    thresh_reg    <= stg_thresh;
                    acc_reg       <= '0;
                    feat_cnt_reg  <= '0;
                end
                REQ: begin
                    if (xfer) begin
                        acc_reg      <= acc_next;
                        feat_cnt_reg <= feat_cnt_reg + 1'b1;
                    end
                end
                CMP: begin
                    stage_done_reg   <= 1'b1;
                    stage_passed_reg <= (acc_reg >= thresh_reg);
                    if ((acc_reg >= thresh_reg) && !is_last) begin
                        stage_idx_reg <= stage_idx_reg + 1'b1;
                        feat_base_reg <= feat_base_reg + num_feats_reg;
                    end else begin
                        stage_idx_reg <= '0;
                        feat_base_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_stage_eval.sv
// Scoreboard bench for cascade_stage_eval: stage results are queued at start and
// checked by a monitor on stage_done; a responder model supplies votes.
module tb_cascade_stage_eval;
    localparam int NS = 25;
    localparam int SW = 5;
    localparam int FW = 12;
    localparam int VW = 16;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 stage_start = 1'b0;
    logic                 window_reset = 1'b0;
    logic                 stage_done, stage_passed, last_stage;
    logic [SW-1:0]        stage_idx;
    logic [FW-1:0]        stg_num_feats;
    logic signed [AW-1:0] stg_thresh;

    cascade_stage_eval_if #(.FIDX_W(FW), .VOTE_W(VW)) bus ();

    cascade_stage_eval #(
        .NUM_STAGES(NS), .SIDX_W(SW), .FIDX_W(FW), .VOTE_W(VW), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .stage_start(stage_start), .window_reset(window_reset),
        .stage_done(stage_done), .stage_passed(stage_passed), .last_stage(last_stage),
        .stage_idx(stage_idx), .stg_num_feats(stg_num_feats), .stg_thresh(stg_thresh),
        .feat(bus.master)
    );

    // Narrow-accumulator instance for the overflow behaviour.
    logic              start2 = 1'b0;
    logic              done2, passed2, last2;
    logic [0:0]        idx2;
    logic [FW-1:0]     nf2 = 12'd2;
    logic signed [7:0] th2 = 8'sd127;

    cascade_stage_eval_if #(.FIDX_W(FW), .VOTE_W(8)) bus2 ();
    assign bus2.feat_ack  = 1'b1;
    assign bus2.feat_vote = 8'sd100;

    cascade_stage_eval #(
        .NUM_STAGES(2), .SIDX_W(1), .FIDX_W(FW), .VOTE_W(8), .ACC_W(8)
    ) dut2 (
        .clk(clk), .rst(rst), .stage_start(start2), .window_reset(1'b0),
        .stage_done(done2), .stage_passed(passed2), .last_stage(last2),
        .stage_idx(idx2), .stg_num_feats(nf2), .stg_thresh(th2),
        .feat(bus2.master)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage table ROM with one cycle of read latency.
    logic [FW-1:0]        rom_nf [NS];
    logic signed [AW-1:0] rom_th [NS];
    always @(posedge clk) begin
        stg_num_feats <= rom_nf[stage_idx];
        stg_thresh    <= rom_th[stage_idx];
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Feature-sum responder: acks after ack_delay idle REQ cycles, checks feat_idx.
    int ack_delay = 0;
    int wcnt = 0;
    int vote_q[$];
    int fi_q[$];
    always @(negedge clk) begin
        if (bus.feat_ack || !bus.feat_req) wcnt = 0;
        bus.feat_ack = 1'b0;
        if (rst && bus.feat_req) begin
            if (wcnt >= ack_delay) begin
                bus.feat_ack  = 1'b1;
                bus.feat_vote = (vote_q.size() > 0) ? VW'(vote_q.pop_front()) : '0;
                if (fi_q.size() > 0) begin
                    check("feat_idx", bus.feat_idx, fi_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_feat_req: feat_idx=%0d with no request expected", bus.feat_idx);
                end
            end else begin
                wcnt++;
            end
        end
    end

    typedef struct {
        int passed;
        int idx;
        int last;
        int cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    always @(negedge clk) begin
        if (rst && stage_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: stage_done=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb_q.pop_front();
                check("stage_passed", stage_passed, e.passed);
                check("stage_idx_after", stage_idx, e.idx);
                check("last_stage_after", last_stage, e.last);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_stage(input int passed, input int idx, input int last,
                             input int lat, input int delay);
        int k;
        ack_delay = delay;
        sb_q.push_back('{passed, idx, last, cyc + 1 + lat});
        stage_start = 1'b1;
        @(negedge clk);
        stage_start = 1'b0;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no stage_done within 200 cycles, required one");
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c0;
        int exp2;
        for (int i = 0; i < NS; i++) begin
            rom_nf[i] = '0;
            rom_th[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_stage_done", stage_done, 0);
        check("rst_stage_passed", stage_passed, 0);
        check("rst_feat_req", bus.feat_req, 0);
        check("rst_feat_idx", bus.feat_idx, 0);
        check("rst_stage_idx", stage_idx, 0);
        check("rst_last_stage", last_stage, 0);
        rst = 1'b1;
        @(negedge clk);

        // Stage 0: 4+5+2=11 >= 10, immediate acks.
        rom_nf[0] = 12'd3; rom_th[0] = 24'sd10;
        vote_q = '{4, 5, 2}; fi_q = '{0, 1, 2};
        run_stage(1, 1, 0, 5, 0);

        // Stage 1: -3+1=-2 < 0, acks delayed 2 cycles.
        rom_nf[1] = 12'd2; rom_th[1] = 24'sd0;
        vote_q = '{-3, 1}; fi_q = '{3, 4};
        run_stage(0, 0, 0, 8, 2);

        // Pass all stages; stage 0 has no features.
        for (int i = 0; i < NS; i++) begin
            rom_nf[i] = (i == 0) ? 12'd0 : 12'd1;
            rom_th[i] = 24'sd0;
        end
        for (int i = 0; i < NS; i++) begin
            if (i > 0) begin
                vote_q.push_back(0);
                fi_q.push_back(i - 1);
            end
            run_stage(1, (i + 1) % NS, (i == NS - 2) ? 1 : 0, (i == 0) ? 2 : 3, 0);
        end

        // Stages 0..2 pass against a negative threshold, then abort stage 3.
        for (int i = 0; i < 3; i++) begin
            rom_nf[i] = 12'd1;
            rom_th[i] = -24'sd5;
        end
        rom_nf[3] = 12'd4; rom_th[3] = 24'sd0;
        for (int i = 0; i < 3; i++) begin
            vote_q.push_back(0);
            fi_q.push_back(i);
            run_stage(1, i + 1, 0, 3, 0);
        end
        ack_delay = 50;
        stage_start = 1'b1;
        @(negedge clk);
        stage_start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_req_active", bus.feat_req, 1);
        check("abort_feat_idx", bus.feat_idx, 3);
        window_reset = 1'b1;
        stage_start  = 1'b1;
        @(negedge clk);
        window_reset = 1'b0;
        stage_start  = 1'b0;
        check("abort_feat_req", bus.feat_req, 0);
        check("abort_stage_idx", stage_idx, 0);
        check("abort_stage_done", stage_done, 0);
        repeat (6) @(negedge clk);
        check("abort_start_ignored", bus.feat_req, 0);
        check("abort_base_cleared", bus.feat_idx, 0);

        rom_nf[0] = 12'd1; rom_th[0] = 24'sd7;
        vote_q = '{7}; fi_q = '{0};
        run_stage(1, 1, 0, 3, 0);

        // 8-bit accumulator: 100+100 saturates to 127 or wraps to -56.
`ifdef CASCADE_ACC_SAT_EN
        exp2 = 1;
`else
        exp2 = 0;
`endif
        start2 = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done2) begin
            checks++;
            errors++;
            $display("FAIL acc8_timeout: no stage_done within 20 cycles, required one");
        end else begin
            check("acc8_passed", passed2, exp2);
            check("acc8_done_cycle", cyc, c0 + 1 + 4);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
